// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch redirect controller.
package branch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    DRAIN
  } state_e;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Front-end sequencer for resolved branches: on a direction mispredict it issues a
// PC redirect over valid/ready, then flushes IF/ID and ID/EX, and counts branches.
module branch_redirect_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_is_ctrl,
  input  logic             ex_should_branch,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             ex_stall,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int unsigned DW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [DW-1:0]   r_drain;
  logic [DW-1:0]   w_drain_nxt;
  logic [XLEN-1:0] r_redirect_pc;
  logic [XLEN-1:0] w_correct_pc;
  logic            w_fire;
  logic            w_mis;

  // EX contents are only meaningful while idle; otherwise they are squashed bubbles.
  assign w_fire       = ex_valid & ex_is_ctrl & (r_state == IDLE);
  assign w_mis        = w_fire & (ex_should_branch != ex_pred_taken);
  assign w_correct_pc = ex_should_branch ? ex_target : (ex_pc + XLEN'(PC_INC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_drain       <= '0;
      r_redirect_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= w_drain_nxt;
      if (w_mis) begin
        r_redirect_pc <= w_correct_pc;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain;
    unique case (r_state)
      IDLE: begin
        if (w_mis) begin
          w_state_nxt = REDIRECT;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          if (FLUSH_CYCLES > 0) begin
            w_state_nxt = DRAIN;
            w_drain_nxt = DW'(FLUSH_CYCLES);
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      DRAIN: begin
        w_drain_nxt = r_drain - DW'(1);
        if (r_drain == DW'(1)) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_drain_nxt = '0;
      end
    endcase
  end

  // Outputs decode the state flops only, so reset clears them without a clock edge.
  always_comb begin
    redirect_valid = 1'b0;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    ex_stall       = 1'b0;
    unique case (r_state)
      IDLE: ;
      REDIRECT: begin
        redirect_valid = 1'b1;
        flush_if_id    = 1'b1;
        flush_id_ex    = 1'b1;
        ex_stall       = 1'b1;
      end
      DRAIN: begin
        flush_if_id = 1'b1;
        ex_stall    = 1'b1;
      end
      default: ;
    endcase
  end

  assign redirect_pc = r_redirect_pc;

  sat_counter #(
    .W(CNT_W)
  ) u_branch_cnt (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_inc  (w_fire),
    .i_clr  (cnt_clear),
    .o_count(branch_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_mispredict_cnt (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_inc  (w_mis),
    .i_clr  (cnt_clear),
    .o_count(mispredict_cnt)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench: two controllers (FLUSH_CYCLES=2/CNT_W=4 and FLUSH_CYCLES=0/CNT_W=16) on shared
// stimulus, checked every cycle against a behavioural model plus directed literal checks.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_is_ctrl, ex_should_branch, ex_pred_taken;
  logic [31:0] ex_pc, ex_target;
  logic        redirect_ready, cnt_clear;

  logic        rv0, rv1, fi0, fi1, fe0, fe1, st0, st1;
  logic [31:0] rpc0, rpc1;
  logic [3:0]  bc0, mc0;
  logic [15:0] bc1, mc1;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(
    .XLEN(32), .FLUSH_CYCLES(2), .CNT_W(4)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_ctrl(ex_is_ctrl),
    .ex_should_branch(ex_should_branch), .ex_pred_taken(ex_pred_taken),
    .ex_pc(ex_pc), .ex_target(ex_target), .redirect_valid(rv0), .redirect_pc(rpc0),
    .redirect_ready(redirect_ready), .flush_if_id(fi0), .flush_id_ex(fe0),
    .ex_stall(st0), .cnt_clear(cnt_clear), .branch_cnt(bc0), .mispredict_cnt(mc0)
  );

  branch_redirect_ctrl #(
    .XLEN(32), .FLUSH_CYCLES(0), .CNT_W(16)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_ctrl(ex_is_ctrl),
    .ex_should_branch(ex_should_branch), .ex_pred_taken(ex_pred_taken),
    .ex_pc(ex_pc), .ex_target(ex_target), .redirect_valid(rv1), .redirect_pc(rpc1),
    .redirect_ready(redirect_ready), .flush_if_id(fi1), .flush_id_ex(fe1),
    .ex_stall(st1), .cnt_clear(cnt_clear), .branch_cnt(bc1), .mispredict_cnt(mc1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: "redirect outstanding" flag plus remaining flush cycles per instance.
  int          fc_p[2]  = '{2, 0};
  int          max_p[2] = '{15, 65535};
  bit          m_redir[2];
  int          m_drain[2];
  logic [31:0] m_pc[2];
  int          m_b[2];
  int          m_m[2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_redir[k] = 1'b0;
        m_drain[k] = 0;
        m_pc[k]    = 32'h0;
        m_b[k]     = 0;
        m_m[k]     = 0;
      end else begin
        if (!m_redir[k] && m_drain[k] == 0) begin
          if (ex_valid && ex_is_ctrl) begin
            if (m_b[k] < max_p[k]) m_b[k] = m_b[k] + 1;
            if (ex_should_branch != ex_pred_taken) begin
              if (m_m[k] < max_p[k]) m_m[k] = m_m[k] + 1;
              m_redir[k] = 1'b1;
              m_pc[k]    = ex_should_branch ? ex_target : ex_pc + 32'd4;
            end
          end
        end else if (m_redir[k]) begin
          if (redirect_ready) begin
            m_redir[k] = 1'b0;
            m_drain[k] = fc_p[k];
          end
        end else begin
          m_drain[k] = m_drain[k] - 1;
        end
        if (cnt_clear) begin
          m_b[k] = 0;
          m_m[k] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("rv0", 64'(rv0), 64'(m_redir[0]));
      check("rpc0", 64'(rpc0), 64'(m_pc[0]));
      check("fi0", 64'(fi0), 64'(m_redir[0] || m_drain[0] > 0));
      check("fe0", 64'(fe0), 64'(m_redir[0]));
      check("st0", 64'(st0), 64'(m_redir[0] || m_drain[0] > 0));
      check("bc0", 64'(bc0), 64'(m_b[0]));
      check("mc0", 64'(mc0), 64'(m_m[0]));
      check("rv1", 64'(rv1), 64'(m_redir[1]));
      check("rpc1", 64'(rpc1), 64'(m_pc[1]));
      check("fi1", 64'(fi1), 64'(m_redir[1] || m_drain[1] > 0));
      check("fe1", 64'(fe1), 64'(m_redir[1]));
      check("st1", 64'(st1), 64'(m_redir[1] || m_drain[1] > 0));
      check("bc1", 64'(bc1), 64'(m_b[1]));
      check("mc1", 64'(mc1), 64'(m_m[1]));
    end
  end

  task automatic set_br(input logic v, input logic sb, input logic pt,
                        input logic [31:0] pc, input logic [31:0] tgt);
    ex_valid         = v;
    ex_is_ctrl       = v;
    ex_should_branch = sb;
    ex_pred_taken    = pt;
    ex_pc            = pc;
    ex_target        = tgt;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    set_br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    redirect_ready = 1'b0;
    cnt_clear      = 1'b0;
    cyc(2);
    rst_n    = 1'b1;
    check_en = 1'b1;
    cyc(1);
    check("reset_rv", 64'(rv0), 64'd0);
    check("reset_rpc", 64'(rpc0), 64'd0);
    check("reset_bc", 64'(bc0), 64'd0);

    // Correct prediction: counted, no redirect
    set_br(1'b1, 1'b1, 1'b1, 32'h40, 32'h80);
    cyc(1);
    set_br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t1_bc", 64'(bc0), 64'd1);
    check("t1_mc", 64'(mc0), 64'd0);
    check("t1_rv", 64'(rv0), 64'd0);
    check("t1_fi", 64'(fi0), 64'd0);
    cyc(2);

    // Taken mispredict, ready tied high
    redirect_ready = 1'b1;
    set_br(1'b1, 1'b1, 1'b0, 32'h100, 32'h200);
    cyc(1);
    set_br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t2_rv", 64'(rv0), 64'd1);
    check("t2_rpc", 64'(rpc0), 64'h200);
    check("t2_fi", 64'(fi0), 64'd1);
    check("t2_fe", 64'(fe0), 64'd1);
    check("t2_mc", 64'(mc0), 64'd1);
    cyc(1);
    check("t2_d1_rv", 64'(rv0), 64'd0);
    check("t2_d1_fi", 64'(fi0), 64'd1);
    check("t2_d1_fe", 64'(fe0), 64'd0);
    cyc(1);
    check("t2_d2_fi", 64'(fi0), 64'd1);
    cyc(1);
    check("t2_idle_fi", 64'(fi0), 64'd0);
    check("t2_idle_st", 64'(st0), 64'd0);
    cyc(2);

    // Not-taken mispredict at top of address space, fetch stalls 3 cycles
    redirect_ready = 1'b0;
    set_br(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1234);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("t3_rv", 64'(rv0), 64'd1);
      check("t3_rpc", 64'(rpc0), 64'h0);
      check("t3_st", 64'(st0), 64'd1);
    end
    set_br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    redirect_ready = 1'b1;
    cyc(1);
    check("t3_after_rv", 64'(rv0), 64'd0);
    check("t3_bc", 64'(bc0), 64'd3);
    check("t3_mc", 64'(mc0), 64'd2);
    cyc(4);

    // Asynchronous reset in the middle of a redirect
    redirect_ready = 1'b0;
    set_br(1'b1, 1'b1, 1'b0, 32'h500, 32'h600);
    cyc(1);
    check("t4_rv_pre", 64'(rv0), 64'd1);
    #2;
    rst_n = 1'b0;
    set_br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("t4_rv", 64'(rv0), 64'd0);
    check("t4_fi", 64'(fi0), 64'd0);
    check("t4_fe", 64'(fe0), 64'd0);
    check("t4_st", 64'(st0), 64'd0);
    check("t4_rv1", 64'(rv1), 64'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    check("t4_bc", 64'(bc0), 64'd0);
    check("t4_mc", 64'(mc0), 64'd0);
    check("t4_rpc", 64'(rpc0), 64'd0);

    // Saturation: dut0 takes one mispredict every 4 cycles -> 18 in 70 cycles
    redirect_ready = 1'b1;
    set_br(1'b1, 1'b1, 1'b0, 32'h700, 32'h800);
    cyc(70);
    check("t5_bc_sat", 64'(bc0), 64'd15);
    check("t5_mc_sat", 64'(mc0), 64'd15);
    cnt_clear = 1'b1;
    cyc(1);
    cnt_clear = 1'b0;
    set_br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t5_bc0_clr", 64'(bc0), 64'd0);
    check("t5_mc0_clr", 64'(mc0), 64'd0);
    check("t5_bc1_clr", 64'(bc1), 64'd0);
    check("t5_mc1_clr", 64'(mc1), 64'd0);
    cyc(6);

    // FLUSH_CYCLES=0: one-cycle redirect, back-to-back mispredict accepted
    set_br(1'b1, 1'b1, 1'b0, 32'h300, 32'h400);
    cyc(1);
    check("t6_rv", 64'(rv1), 64'd1);
    check("t6_rpc", 64'(rpc1), 64'h400);
    ex_target = 32'h500;
    cyc(1);
    check("t6_idle_rv", 64'(rv1), 64'd0);
    check("t6_idle_st", 64'(st1), 64'd0);
    cyc(1);
    check("t6_rv2", 64'(rv1), 64'd1);
    check("t6_rpc2", 64'(rpc1), 64'h500);
    set_br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(4);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      ex_valid         = 1'($urandom_range(0, 1));
      ex_is_ctrl       = 1'($urandom_range(0, 3) != 0);
      ex_should_branch = 1'($urandom_range(0, 1));
      ex_pred_taken    = 1'($urandom_range(0, 1));
      ex_pc            = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom, 2'b00} >> 2 << 2;
      ex_target        = $urandom;
      redirect_ready   = 1'($urandom_range(0, 9) < 7);
      cnt_clear        = 1'($urandom_range(0, 39) == 0);
      cyc(1);
    end
    set_br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cnt_clear = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences the front-end after each branch/jump resolved in EX. It takes the branch unit's should_branch decision and the fetch stage's predicted direction. On a mismatch it issues a PC redirect to fetch over a valid/ready handshake, then flushes IF/ID and ID/EX. It also keeps saturating branch and mispredict counters for performance readout.

Parameters:
XLEN, 32, PC and target width
FLUSH_CYCLES, 2, extra cycles flush_if_id stays high after redirect handshake (squashes in-flight stale fetches); 0 allowed
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX holds a valid instruction this cycle
ex_is_ctrl  in  1  EX instruction is branch/jump (control_flags nonzero)
ex_should_branch  in  1  branch unit resolution: taken
ex_pred_taken  in  1  direction predicted at fetch
ex_pc  in  XLEN  PC of EX instruction
ex_target  in  XLEN  computed branch/jump target
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  XLEN  corrected fetch PC
redirect_ready  in  1  fetch accepts redirect
flush_if_id  out  1  squash IF/ID register
flush_id_ex  out  1  squash ID/EX register
ex_stall  out  1  hold EX; controller busy
cnt_clear  in  1  synchronous clear of both counters
branch_cnt  out  CNT_W  resolved control instructions
mispredict_cnt  out  CNT_W  mispredicted control instructions

Behaviour:
- Reset (async, immediate):
  - state IDLE.
  - redirect_valid, flush_if_id, flush_id_ex, ex_stall = 0.
  - redirect_pc = 0; counters = 0; drain counter = 0.
  - A reset during REDIRECT/DRAIN aborts the sequence; redirect_valid drops without waiting for a clock edge.
- All outputs are registered; nothing is combinational from inputs.
- Resolve condition: fire = ex_valid & ex_is_ctrl, evaluated only in IDLE.
- Mispredict condition: mis = fire & (ex_should_branch != ex_pred_taken).
- Correct PC: ex_target if ex_should_branch, else ex_pc + 4. Arithmetic is modulo 2^XLEN, so wrap from all-ones to 0x3 is legal.
- State IDLE:
  - All control outputs 0.
  - On mis: capture the correct PC into redirect_pc and go to REDIRECT.
  - Next cycle, redirect_valid, flush_if_id, flush_id_ex and ex_stall are all 1 (latency 1 from detection).
- State REDIRECT:
  - Hold redirect_valid, redirect_pc, both flushes and ex_stall stable until redirect_ready.
  - On the handshake cycle (redirect_valid & redirect_ready): if FLUSH_CYCLES>0, go to DRAIN with the drain counter loaded to FLUSH_CYCLES; otherwise go to IDLE.
  - redirect_valid is 0 the cycle after the handshake.
- State DRAIN:
  - flush_if_id=1, flush_id_ex=0, ex_stall=1, redirect_valid=0.
  - Decrement the counter each cycle; go to IDLE on the cycle the counter reaches 1→0.
  - This gives exactly FLUSH_CYCLES cycles of flush_if_id after the handshake.
- ex_valid and ex_is_ctrl are ignored outside IDLE (EX holds squashed bubbles); they are neither counted nor redirected.
- Correctly predicted control ops cause no state change and no flush.
- Counters:
  - branch_cnt += 1 on fire; mispredict_cnt += 1 on mis.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - cnt_clear has priority over a same-cycle increment; the result is 0.

Decomposition:
- Package branch_ctrl_pkg: state enum {IDLE, REDIRECT, DRAIN} (2-bit), constant PC_INC = 4.
- One sub-module sat_counter (parameter W; inputs inc and clr; output count), instantiated twice for the counters.
- FSM, redirect register and drain counter stay in branch_redirect_ctrl.

Test Plan:
1. Correct prediction: ex_valid=1, ex_is_ctrl=1, should_branch=1, pred_taken=1 -> no redirect/flush ever; branch_cnt=1, mispredict_cnt=0.
2. Taken mispredict: pc=0x100, target=0x200, should_branch=1, pred=0; redirect_ready=1 tied -> next cycle redirect_valid=1, redirect_pc=0x200, both flushes=1; with FLUSH_CYCLES=2, flush_if_id high for 2 more cycles; back in IDLE on cycle 4; mispredict_cnt=1.
3. Not-taken mispredict with backpressure: pc=0xFFFF_FFFC, should_branch=0, pred=1; redirect_ready low 3 cycles -> redirect_pc=0x0000_0000 (wrap), held stable 4 cycles; a fire presented during the stall is not counted.
4. Reset mid-sequence: assert rst_n=0 during REDIRECT -> redirect_valid, flushes and ex_stall go 0 asynchronously; after release, IDLE and counters read 0.
5. Saturation and clear: CNT_W=4, 16 mispredicts -> both counters=15; cnt_clear together with a fire -> both counters 0.
6. FLUSH_CYCLES=0: on mispredict with ready=1 -> redirect for exactly 1 cycle, IDLE the next cycle, and a back-to-back mispredict is accepted immediately.
